// File: rtl/pending_encoder16to4_pkg.sv
// Shared widths and FSM encoding for the pending-request encoder.
package pending_encoder16to4_pkg;

   localparam int unsigned ENC_N     = 16;
   localparam int unsigned ENC_IDX_W = 4;
   localparam int unsigned ENC_CNT_W = 5;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } enc_state_e;

endpackage : pending_encoder16to4_pkg

// File: rtl/pending_encoder16to4_prio_enc16.sv
// Rotating priority encoder: lowest set bit of vec at or above base, wrapping 15->0.
module prio_enc16
   import pending_encoder16to4_pkg::*;
(
   input  logic [ENC_N-1:0]     vec,
   input  logic [ENC_IDX_W-1:0] base,
   output logic [ENC_IDX_W-1:0] idx,
   output logic                 found
);

   logic [ENC_N-1:0]     rot;
   logic [ENC_IDX_W-1:0] off;

   // rot[i] is vec[(base + i) mod 16]; the 4-bit sum wraps naturally
   always_comb begin : rotate
      logic [ENC_IDX_W-1:0] j;
      rot = '0;
      j   = '0;
      for (int i = 0; i < int'(ENC_N); i++) begin
         j      = ENC_IDX_W'(i) + base;
         rot[i] = vec[j];
      end
   end

   always_comb begin : lowest
      off = '0;
      for (int i = int'(ENC_N) - 1; i >= 0; i--) begin
         if (rot[i]) off = ENC_IDX_W'(i);
      end
   end

   assign idx   = off + base;
   assign found = |vec;

endmodule : prio_enc16

// File: rtl/pending_encoder16to4.sv
// Collects request vectors into a pending set and hands out one encoded index per handshake.
module pending_encoder16to4
   import pending_encoder16to4_pkg::*;
#(
   parameter int unsigned RR_MODE = 0
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [ENC_N-1:0]     in_vec,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ENC_IDX_W-1:0] out_idx,
   output logic [ENC_N-1:0]     out_onehot,
   output logic [ENC_N-1:0]     pending,
   output logic [ENC_CNT_W-1:0] pend_cnt
);

   enc_state_e           state_q, state_d;
   logic [ENC_N-1:0]     pending_q, pending_d;
   logic [ENC_IDX_W-1:0] out_idx_q, out_idx_d;
   logic [ENC_IDX_W-1:0] ptr_q, ptr_d;

   logic                 hs;
   logic [ENC_N-1:0]     clr, newv, nxt;
   logic [ENC_IDX_W-1:0] base;
   logic [ENC_IDX_W-1:0] sel_idx;
   logic                 sel_found;

   // Pending-set update; the pointer advances before selection so a hit is not re-granted first
   always_comb begin : datapath
      hs    = (state_q == PRESENT) && out_ready;
      clr   = hs ? (ENC_N'(1) << out_idx_q) : '0;
      newv  = in_valid ? in_vec : '0;
      nxt   = (pending_q & ~clr) | newv;
      ptr_d = hs ? (out_idx_q + ENC_IDX_W'(1)) : ptr_q;
      base  = (RR_MODE != 0) ? ptr_d : '0;
   end

   prio_enc16 u_prio (
      .vec   (nxt),
      .base  (base),
      .idx   (sel_idx),
      .found (sel_found)
   );

   always_comb begin : fsm
      state_d   = state_q;
      out_idx_d = out_idx_q;
      pending_d = nxt;
      unique case (state_q)
         IDLE: begin
            if (sel_found) begin
               out_idx_d = sel_idx;
               state_d   = PRESENT;
            end
         end
         PRESENT: begin
            // out_idx is held until accepted; no preemption by later requests
            if (hs) begin
               if (sel_found) out_idx_d = sel_idx;
               else           state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         out_idx_q <= '0;
         ptr_q     <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         out_idx_q <= out_idx_d;
         ptr_q     <= ptr_d;
      end
   end

   always_comb begin : popcount
      pend_cnt = '0;
      for (int i = 0; i < int'(ENC_N); i++) begin
         pend_cnt = pend_cnt + ENC_CNT_W'(pending_q[i]);
      end
   end

   assign out_valid  = (state_q == PRESENT);
   assign out_idx    = out_idx_q;
   assign pending    = pending_q;
   assign out_onehot = out_valid ? (ENC_N'(1) << out_idx_q) : '0;

endmodule : pending_encoder16to4

// File: tb/tb_pending_encoder16to4.sv
// Drives a fixed-priority and a round-robin instance with shared stimulus against a reference model.
module tb_pending_encoder16to4;

   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready;
   logic [15:0] in_vec;

   logic        ov0, ov1;
   logic [3:0]  oi0, oi1;
   logic [15:0] oh0, oh1, pd0, pd1;
   logic [4:0]  pc0, pc1;

   int n_tests = 0;
   int n_fail  = 0;

   // reference state per instance: [0] fixed priority, [1] round-robin
   logic [15:0] m_pend [2];
   logic        m_valid[2];
   int          m_idx  [2];
   int          m_ptr  [2];

   always #5 clk = ~clk;

   pending_encoder16to4 #(.RR_MODE(0)) u_fix (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_vec(in_vec),
      .out_valid(ov0), .out_ready(out_ready), .out_idx(oi0),
      .out_onehot(oh0), .pending(pd0), .pend_cnt(pc0)
   );

   pending_encoder16to4 #(.RR_MODE(1)) u_rr (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_vec(in_vec),
      .out_valid(ov1), .out_ready(out_ready), .out_idx(oi1),
      .out_onehot(oh1), .pending(pd1), .pend_cnt(pc1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int popc(input logic [15:0] v);
      int c = 0;
      for (int i = 0; i < 16; i++) if (v[i]) c++;
      return c;
   endfunction

   function automatic int first_from(input logic [15:0] v, input int base);
      for (int k = 0; k < 16; k++) begin
         if (v[(base + k) % 16]) return (base + k) % 16;
      end
      return -1;
   endfunction

   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            m_pend[m] = '0; m_valid[m] = 1'b0; m_idx[m] = 0; m_ptr[m] = 0;
         end else begin
            bit hs = m_valid[m] && out_ready;
            logic [15:0] clrv = hs ? (16'd1 << m_idx[m]) : 16'd0;
            m_pend[m] = (m_pend[m] & ~clrv) | (in_valid ? in_vec : 16'd0);
            if (hs) m_ptr[m] = (m_idx[m] + 1) % 16;
            if (!m_valid[m] || hs) begin
               if (m_pend[m] != 0) begin
                  m_idx[m]   = first_from(m_pend[m], (m == 1) ? m_ptr[m] : 0);
                  m_valid[m] = 1'b1;
               end else begin
                  m_valid[m] = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      for (int m = 0; m < 2; m++) begin
         logic        gv  = (m == 1) ? ov1 : ov0;
         logic [3:0]  gi  = (m == 1) ? oi1 : oi0;
         logic [15:0] gh  = (m == 1) ? oh1 : oh0;
         logic [15:0] gp  = (m == 1) ? pd1 : pd0;
         logic [4:0]  gc  = (m == 1) ? pc1 : pc0;
         logic [15:0] exp_oh = m_valid[m] ? (16'd1 << m_idx[m]) : 16'd0;
         check($sformatf("m%0d_valid", m), 32'(gv), 32'(m_valid[m]));
         check($sformatf("m%0d_pending", m), 32'(gp), 32'(m_pend[m]));
         check($sformatf("m%0d_cnt", m), 32'(gc), 32'(popc(m_pend[m])));
         check($sformatf("m%0d_onehot", m), 32'(gh), 32'(exp_oh));
         if (m_valid[m]) begin
            check($sformatf("m%0d_idx", m), 32'(gi), 32'(m_idx[m]));
            check($sformatf("m%0d_inv", m), 32'(gp[gi]), 32'd1);
         end
      end
   endtask

   // Apply one cycle of stimulus, advance the model, check just after the edge
   task automatic cycle(input logic r, input logic iv, input logic [15:0] v, input logic rdy);
      @(negedge clk);
      rst = r; in_valid = iv; in_vec = v; out_ready = rdy;
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   initial begin
      int seq_8421[4] = '{0, 5, 10, 15};
      rst = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;

      // reset state, then reset over a full pending set mid-handshake
      cycle(1, 0, 16'h0000, 0);
      check("rst_idx", 32'(oi0), 32'd0);
      check("rst_valid", 32'(ov1), 32'd0);
      cycle(0, 1, 16'hFFFF, 0);
      check("full_cnt", 32'(pc0), 32'd16);
      cycle(1, 1, 16'hFFFF, 1);
      check("rst_pend", 32'(pd0), 32'd0);
      check("rst_cnt", 32'(pc1), 32'd0);
      check("rst_valid_mid", 32'(ov0), 32'd0);

      // fixed priority drain of 8421
      cycle(0, 1, 16'h8421, 1);
      check("fp_seq0", 32'(oi0), 32'(seq_8421[0]));
      for (int k = 1; k < 4; k++) begin
         cycle(0, 0, 16'h0000, 1);
         check($sformatf("fp_seq%0d", k), 32'(oi0), 32'(seq_8421[k]));
      end
      cycle(0, 0, 16'h0000, 1);
      check("fp_empty_valid", 32'(ov0), 32'd0);
      check("fp_empty_pend", 32'(pd0), 32'd0);

      // backpressure: index held while a lower one arrives
      cycle(0, 1, 16'h0010, 0);
      cycle(0, 1, 16'h0001, 0);
      cycle(0, 0, 16'h0000, 0);
      check("bp_hold_idx", 32'(oi0), 32'd4);
      check("bp_pend", 32'(pd0), 32'h0011);
      cycle(0, 0, 16'h0000, 1);
      check("bp_next_idx", 32'(oi0), 32'd0);
      cycle(0, 0, 16'h0000, 1);
      check("bp_done", 32'(ov0), 32'd0);

      // round-robin with every bit re-requested each cycle
      cycle(1, 0, 16'h0000, 0);
      cycle(0, 1, 16'hFFFF, 1);
      check("rr_seq0", 32'(oi1), 32'd0);
      for (int k = 1; k < 18; k++) begin
         cycle(0, 1, 16'hFFFF, 1);
         check($sformatf("rr_seq%0d", k), 32'(oi1), 32'(k % 16));
      end

      // same-bit collision: new request wins over the clear
      cycle(1, 0, 16'h0000, 0);
      cycle(0, 1, 16'h0008, 0);
      cycle(0, 1, 16'h0008, 1);
      check("col_idx", 32'(oi0), 32'd3);
      check("col_valid", 32'(ov0), 32'd1);
      check("col_pend", 32'(pd1), 32'h0008);
      cycle(0, 0, 16'h0000, 1);
      check("col_drain", 32'(ov0), 32'd0);

      // loopback decode for every index
      for (int i = 0; i < 16; i++) begin
         logic [15:0] dec = 16'd1 << i;
         cycle(0, 1, dec, 1);
         check($sformatf("lb_%0d", i), 32'(oh0), 32'(dec));
      end
      cycle(0, 0, 16'h0000, 1);

      // randomized traffic with occasional reset
      for (int n = 0; n < 400; n++) begin
         logic [15:0] v = 16'($urandom) & 16'($urandom);
         logic        r = ($urandom_range(0, 63) == 0);
         cycle(r, 1'($urandom), v, 1'($urandom_range(0, 3) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_pending_encoder16to4

// File: doc/pending_encoder16to4.md
Name: pending_encoder16to4

Overview:
- Sequential 16-to-4 encoder that works in the reverse direction from the team's 4-to-16 decoders.
- Accumulates one-hot/multi-hot request vectors into a 16-bit pending set.
- Presents one pending index per handshake as a 4-bit code, with a valid/ready output interface.
- Used as the request-collection front end that feeds encoded indices to downstream decode4to16-based selectors.

Parameters:
- RR_MODE, 0, 0 = fixed priority (lowest index first); 1 = round-robin starting after the last granted index.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_vec is sampled this cycle.
- in_vec  input  16  request bits; OR-merged into the pending set when in_valid=1. Always accepted; no in_ready.
- out_valid  output  1  out_idx holds a pending request.
- out_ready  input  1  consumer accepts out_idx this cycle.
- out_idx  output  4  encoded index of the presented request.
- out_onehot  output  16  decode of out_idx when out_valid=1, else 0. Used for loopback checking against decode4to16.
- pending  output  16  current pending set, including the presented bit.
- pend_cnt  output  5  popcount of pending, range 0..16.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pending=0, out_valid=0, out_idx=0, out_onehot=0, pend_cnt=0, rr pointer=0, state=IDLE.
  - Reset overrides every concurrent input, including mid-handshake.
- Per cycle:
  - hs = out_valid & out_ready.
  - clr = hs ? onehot(out_idx) : 0.
  - newv = in_valid ? in_vec : 0.
  - nxt = (pending & ~clr) | newv.
  - pending <= nxt.
- Simultaneous events:
  - If newv sets the same bit that is being cleared, the bit stays set and is presented again later. The new request wins.
- Selection:
  - RR_MODE=0: sel = lowest set bit of nxt.
  - RR_MODE=1: sel = first set bit of nxt scanning upward from ptr, wrapping 15->0. ptr <= out_idx+1 (mod 16) on each hs.
- States:
  - IDLE (out_valid=0):
    - If nxt!=0, load out_idx<=sel, out_valid<=1, go to PRESENT.
    - Latency is 1 clock: in_vec sampled at edge N gives out_valid high after edge N.
  - PRESENT (out_valid=1):
    - No hs: out_idx is held stable even if a higher-priority request arrives. No preemption; AXI-style stability.
    - hs and nxt!=0: load next sel in the same edge. Back-to-back throughput is 1 index per clock.
    - hs and nxt==0: out_valid<=0, go to IDLE.
- Invariant: while out_valid=1, pending[out_idx]=1.
- out_onehot and pend_cnt:
  - Combinational from registered state.
  - pend_cnt is 16 when all bits are pending; it never wraps.
- in_vec=0 with in_valid=1 is legal and has no effect.

Decomposition:
- Shared package/header:
  - ENC_N=16, ENC_IDX_W=4, state encodings IDLE=1'b0 and PRESENT=1'b1.
- Sub-module prio_enc16 (combinational):
  - Inputs: vec[15:0], base[3:0].
  - Outputs: idx[3:0], found.
  - Rotates vec by base, finds the lowest set bit, adds base back mod 16.
  - RR_MODE=0 ties base to 0.
- Top level:
  - Holds pending, ptr and the FSM.
  - Computes pend_cnt and out_onehot inline.

Test Plan:
- Reset behaviour: rst=1 while pending=16'hFFFF and out_valid=1 -> next cycle pending=0, out_valid=0, pend_cnt=0.
- Fixed priority: RR_MODE=0, in_vec=16'h8421 in one cycle, out_ready=1 -> out_idx sequence 0,5,10,15 on consecutive cycles, then out_valid=0, pending=0.
- Backpressure: in_vec=16'h0010 then in_vec=16'h0001 while out_ready=0 -> out_idx stays 4 and pending=16'h0011. Release ready -> outputs 4 then 0.
- Round-robin: RR_MODE=1, pending=16'hFFFF, out_ready=1 for 18 cycles with bits re-requested each cycle -> out_idx 0,1,...,15,0,1 (wraps, no starvation).
- Same-bit collision: out_idx=3 presented, hs and in_vec=16'h0008 in the same cycle -> pending[3] stays 1, out_idx=3 presented again next cycle.
- Loopback: for each idx 0..15 -> out_onehot == 1<<out_idx, and matches decode4to16 driven with out_idx.
